// File: rtl/vram_sync_ctrl.sv
// vram_sync_ctrl: sequences N-segment CPU->VRAM DMA frames and arbitrates VRAM
// between display and sync, so a frame reaches PPU-facing VRAM only when complete.
module vram_sync_ctrl #(
    parameter int ADDR_W = 32,
    parameter int NUM_SEG = 2,
    parameter int CNT_W = 8,
    localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblank_start,
    input  logic              vblank_end_soon,
    input  logic              rowram_swap,
    output logic              rowram_swap_disp,
    output logic              sync_active,
    input  logic [ADDR_W-1:0] srcpio_rddata,
    input  logic              srcpio_update_avail,
    output logic              srcpio_read_rst,
    output logic [ADDR_W-1:0] dma_src_addr,
    output logic [SEG_W-1:0]  dma_seg,
    output logic              dma_start,
    input  logic              dma_finish,
    output logic              vram_sync,
    input  logic              vram_sync_done,
    output logic              dma_rdy_irq,
    output logic              sync_late,
    output logic [CNT_W-1:0]  missed_frames
);
    typedef enum logic [1:0] {IDLE, DISP, SYNC} state_t;

    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);

    state_t state, state_nxt;
    logic [SEG_W-1:0] seg_ptr;
    logic dma_busy, frame_ready, done_seen, late_pending;
    logic accept, first_done, sync_enter, frame_missed, sync_exit;

    assign accept           = srcpio_update_avail && !dma_busy && !frame_ready;
    assign srcpio_read_rst  = accept;
    assign sync_active      = state == SYNC;
    assign rowram_swap_disp = rowram_swap && state == DISP;
    assign first_done       = sync_active && vram_sync_done && !done_seen;
    assign sync_enter       = state == DISP && state_nxt == SYNC;
    assign frame_missed     = state == DISP && state_nxt == IDLE;
    assign sync_exit        = state == SYNC && state_nxt != SYNC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A late sync leaves only once the writer reports done; an on-time one waits for vblank_end_soon.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = vblank_end_soon ? DISP : IDLE;
            DISP: if (vblank_start) state_nxt = frame_ready ? SYNC : IDLE;
            SYNC: if ((vblank_end_soon && (done_seen || vram_sync_done)) ||
                      (vram_sync_done && late_pending)) state_nxt = DISP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_src_addr <= '0;
            dma_seg      <= '0;
            dma_start    <= 1'b0;
            dma_busy     <= 1'b0;
            frame_ready  <= 1'b0;
            seg_ptr      <= '0;
        end else begin
            dma_start <= accept;
            if (accept) begin
                dma_src_addr <= srcpio_rddata;
                dma_seg      <= seg_ptr;
                dma_busy     <= 1'b1;
            end else if (dma_finish && dma_busy) begin
                dma_busy <= 1'b0;
                if (seg_ptr == LAST_SEG)
                    frame_ready <= 1'b1;
                else
                    seg_ptr <= seg_ptr + SEG_W'(1);
            end
            if (first_done) begin
                frame_ready <= 1'b0;
                seg_ptr     <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_sync     <= 1'b0;
            dma_rdy_irq   <= 1'b0;
            sync_late     <= 1'b0;
            missed_frames <= '0;
            done_seen     <= 1'b0;
            late_pending  <= 1'b0;
        end else begin
            vram_sync   <= sync_enter;
            dma_rdy_irq <= first_done;
            if (frame_missed && missed_frames != '1)
                missed_frames <= missed_frames + CNT_W'(1);
            if (sync_exit) begin
                done_seen    <= 1'b0;
                late_pending <= 1'b0;
            end else if (sync_active) begin
                if (vram_sync_done)
                    done_seen <= 1'b1;
                if (vblank_end_soon && !done_seen && !vram_sync_done) begin
                    late_pending <= 1'b1;
                    sync_late    <= 1'b1;
                end
            end
        end
    end
endmodule
